// File: rtl/atb_trace_funnel.sv
// Round-robin ATB funnel: N_SRC trace sources onto one sink, with burst-bounded grants and flush fan-out/ack aggregation.
// Optional build macro ATB_FUNNEL_ID_OVERRIDE_EN replaces source IDs with BASE_ID + source index.
//
// state | meaning
// IDLE  | no owner; search for the next requester starting at rr_ptr (one-cycle bubble)
// GRANT | source[grant] is muxed straight through to the sink until burst limit or valid drop
module atb_trace_funnel #(
    parameter int         N_SRC     = 2,
    parameter int         DATA_LEN  = 32,
    parameter int         MAX_BEATS = 8,
    parameter logic [6:0] BASE_ID   = 7'h10
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [N_SRC-1:0]                        src_atvalid_i,
    input  logic [N_SRC*DATA_LEN-1:0]               src_atdata_i,
    input  logic [N_SRC*($clog2(DATA_LEN)-3)-1:0]   src_atbytes_i,
    input  logic [N_SRC*7-1:0]                      src_atid_i,
    output logic [N_SRC-1:0]                        src_atready_o,
    output logic [N_SRC-1:0]                        src_afvalid_o,
    input  logic [N_SRC-1:0]                        src_afready_i,
    output logic                                    atvalid_o,
    output logic [DATA_LEN-1:0]                     atdata_o,
    output logic [$clog2(DATA_LEN)-4:0]             atbytes_o,
    output logic [6:0]                              atid_o,
    input  logic                                    atready_i,
    input  logic                                    afvalid_i,
    output logic                                    afready_o
);

    localparam int BW = $clog2(DATA_LEN) - 3;
    localparam int PW = $clog2(N_SRC);
    localparam int CW = $clog2(MAX_BEATS + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] grant;
    logic [PW-1:0] rr_ptr;
    logic [CW-1:0] beat_cnt;

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] next_ptr;
    logic          grant_valid;
    logic          accept;
    logic          last_beat;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (src_atvalid_i[(int'(rr_ptr) + k) % N_SRC]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_ptr) + k) % N_SRC);
            end
        end
    end

    assign next_ptr    = (grant == PW'(N_SRC - 1)) ? '0 : grant + PW'(1);
    assign grant_valid = src_atvalid_i[grant];
    assign accept      = (state == ST_GRANT) && grant_valid && atready_i;
    assign last_beat   = (beat_cnt == CW'(MAX_BEATS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        beat_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                    // Valid may only drop after an accept, so leaving here never strands a beat.
                    if ((accept && last_beat) || !grant_valid) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        atvalid_o     = 1'b0;
        atdata_o      = '0;
        atbytes_o     = '0;
        atid_o        = '0;
        src_atready_o = '0;
        if (state == ST_GRANT) begin
            atvalid_o            = grant_valid;
            atdata_o             = src_atdata_i[int'(grant)*DATA_LEN +: DATA_LEN];
            atbytes_o            = src_atbytes_i[int'(grant)*BW +: BW];
`ifdef ATB_FUNNEL_ID_OVERRIDE_EN
            atid_o               = BASE_ID + 7'(grant);
`else
            atid_o               = src_atid_i[int'(grant)*7 +: 7];
`endif
            src_atready_o[grant] = atready_i;
        end
    end

    logic             flush_active;
    logic             flush_done_wait;
    logic [N_SRC-1:0] ack_mask;
    logic [N_SRC-1:0] flush_req;
    logic [N_SRC-1:0] ack_next;
    logic             flush_done;

    assign flush_req     = {N_SRC{flush_active}} & ~ack_mask;
    assign ack_next      = ack_mask | (src_afready_i & flush_req);
    assign flush_done    = flush_active && (&ack_next);
    assign src_afvalid_o = flush_req;
    assign afready_o     = flush_done;

    // done_wait blocks a second flush from the same still-asserted request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_active    <= 1'b0;
            flush_done_wait <= 1'b0;
            ack_mask        <= '0;
        end else if (flush_done) begin
            flush_active    <= 1'b0;
            flush_done_wait <= 1'b1;
            ack_mask        <= ack_next;
        end else if (flush_active) begin
            ack_mask <= ack_next;
        end else if (flush_done_wait) begin
            if (!afvalid_i) begin
                flush_done_wait <= 1'b0;
            end
        end else if (afvalid_i) begin
            flush_active <= 1'b1;
            ack_mask     <= '0;
        end
    end

endmodule

// File: tb/tb_atb_trace_funnel.sv
// Self-checking bench for atb_trace_funnel: directed scenarios then random traffic against a behavioural model.
module tb_atb_trace_funnel;

    localparam int N  = 2;
    localparam int DL = 32;
    localparam int MB = 8;
    localparam int BW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_atvalid;
    logic [N*DL-1:0] src_atdata;
    logic [N*BW-1:0] src_atbytes;
    logic [N*7-1:0]  src_atid;
    logic [N-1:0]    src_atready;
    logic [N-1:0]    src_afvalid;
    logic [N-1:0]    src_afready;
    logic            atvalid;
    logic [DL-1:0]   atdata;
    logic [BW-1:0]   atbytes;
    logic [6:0]      atid;
    logic            atready;
    logic            afvalid;
    logic            afready;

    always #5 clk = ~clk;

    atb_trace_funnel #(.N_SRC(N), .DATA_LEN(DL), .MAX_BEATS(MB), .BASE_ID(7'h10)) dut (
        .clk_i(clk), .rst_i(rst),
        .src_atvalid_i(src_atvalid), .src_atdata_i(src_atdata), .src_atbytes_i(src_atbytes),
        .src_atid_i(src_atid), .src_atready_o(src_atready), .src_afvalid_o(src_afvalid),
        .src_afready_i(src_afready), .atvalid_o(atvalid), .atdata_o(atdata), .atbytes_o(atbytes),
        .atid_o(atid), .atready_i(atready), .afvalid_i(afvalid), .afready_o(afready)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Beats each source still has to deliver, in order; front is the one presented.
    logic [31:0] pend [N][$];
    bit          gap_mode = 1'b0;

    // Reference model: current owner (-1 = none), beats taken this grant, next search start.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_fl    = 0;   // 0 idle, 1 collecting acks, 2 waiting for request drop
    bit m_ack [N];

    int          acc_src  [$];
    int          acc_cyc  [$];
    logic [31:0] acc_data [$];
    logic [6:0]  acc_id   [$];
    int          first_t;
    int          pulse_cnt;
    int          last_pulse;
    logic        last_atvalid;
    logic [31:0] last_atdata;
    logic [N-1:0] last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src(input logic [N-1:0] acc);
        logic [31:0] d;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(pend[i].pop_front());
            if (!(src_atvalid[i] && !acc[i]))
                src_atvalid[i] = (pend[i].size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
            if (src_atvalid[i]) begin
                d = pend[i][0];
                src_atdata[i*DL +: DL]  = d;
                src_atbytes[i*BW +: BW] = d[1:0];
                src_atid[i*7 +: 7]      = d[14:8];
            end
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_ptr = 0; m_fl = 0;
        for (int i = 0; i < N; i++) m_ack[i] = 1'b0;
    endtask

    task automatic clear_logs();
        acc_src.delete(); acc_cyc.delete(); acc_data.delete(); acc_id.delete();
    endtask

    // One clock: check at negedge, advance the model, then drive next inputs after the edge.
    task automatic step();
        logic          exp_v;
        logic [31:0]   exp_d;
        logic [BW-1:0] exp_b;
        logic [6:0]    exp_id;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_afv;
        logic [N-1:0]  acc;
        logic          exp_afr;
        bit            all_ack;
        bit            hit;
        int            idx;
        @(negedge clk);
        if (rst) model_reset();
        exp_v = 1'b0; exp_d = '0; exp_b = '0; exp_id = '0; exp_rdy = '0;
        if (m_owner >= 0) begin
            exp_v  = src_atvalid[m_owner];
            exp_d  = src_atdata[m_owner*DL +: DL];
            exp_b  = src_atbytes[m_owner*BW +: BW];
`ifdef ATB_FUNNEL_ID_OVERRIDE_EN
            exp_id = 7'h10 + 7'(m_owner);
`else
            exp_id = src_atid[m_owner*7 +: 7];
`endif
            exp_rdy[m_owner] = atready;
        end
        all_ack = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_afv[i] = (m_fl == 1) && !m_ack[i];
            if (!(m_ack[i] || (src_afready[i] && exp_afv[i]))) all_ack = 1'b0;
        end
        exp_afr = (m_fl == 1) && all_ack;

        chk("atvalid", atvalid, exp_v);
        chk("atdata", atdata, exp_d);
        chk("atbytes", atbytes, exp_b);
        chk("atid", atid, exp_id);
        chk("src_atready", src_atready, exp_rdy);
        chk("src_afvalid", src_afvalid, exp_afv);
        chk("afready", afready, exp_afr);

        if (atvalid && atready) begin
            idx = -1;
            for (int i = 0; i < N; i++) if (src_atready[i]) idx = i;
            acc_src.push_back(idx); acc_cyc.push_back(cyc);
            acc_data.push_back(atdata); acc_id.push_back(atid);
        end
        if (afready) begin pulse_cnt++; last_pulse = cyc; end
        if (src_afvalid == '1 && first_t < 0) first_t = cyc;
        last_atvalid = atvalid; last_atdata = atdata; last_rdy = src_atready;

        acc = '0;
        if (!rst) begin
            acc = exp_rdy & src_atvalid;
            if (m_owner < 0) begin
                hit = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!hit && src_atvalid[(m_ptr + k) % N]) begin
                        hit = 1'b1; m_owner = (m_ptr + k) % N; m_beats = 0;
                    end
                end
            end else begin
                if (acc[m_owner]) m_beats++;
                if (m_beats == MB || !src_atvalid[m_owner]) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1;
                end
            end
            if (m_fl == 1) begin
                for (int i = 0; i < N; i++) if (exp_afv[i] && src_afready[i]) m_ack[i] = 1'b1;
                if (exp_afr) m_fl = 2;
            end else if (m_fl == 2) begin
                if (!afvalid) m_fl = 0;
            end else if (afvalid) begin
                m_fl = 1;
                for (int i = 0; i < N; i++) m_ack[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_src(acc);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((pend[0].size() + pend[1].size() > 0 || m_owner >= 0) && n < lim) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < lim, 1'b1);
    endtask

    initial begin
        int c0;
        int n;
        logic [31:0] ed;
        rst = 1'b1; src_atvalid = '0; src_atdata = '0; src_atbytes = '0; src_atid = '0;
        src_afready = '0; atready = 1'b1; afvalid = 1'b0;
        first_t = -1; pulse_cnt = 0; last_pulse = -1;
        model_reset();
        #12;
        chk("rst_atvalid", atvalid, 1'b0);
        chk("rst_src_atready", src_atready, '0);
        chk("rst_src_afvalid", src_afvalid, '0);
        chk("rst_afready", afready, 1'b0);
        chk("rst_atdata", atdata, '0);
        step(); step();
        rst = 1'b0;
        step();

        // Single source, three beats, one bubble then back-to-back accepts.
        clear_logs();
        pend[0].push_back(32'hA1); pend[0].push_back(32'hA2); pend[0].push_back(32'hA3);
        drive_src('0);
        c0 = cyc;
        drain(50);
        chk("single_count", acc_src.size(), 3);
        if (acc_src.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk("single_src", acc_src[j], 0);
                chk("single_data", acc_data[j], 32'hA1 + j);
                chk("single_cycle", acc_cyc[j], c0 + 1 + j);
            end
        end

        // Fairness: src1 first (pointer advanced past src0), bursts of exactly MB.
        clear_logs();
        for (int j = 0; j < 16; j++) pend[1].push_back(32'h1000 + j);
        for (int j = 0; j < 8; j++)  pend[0].push_back(32'h2000 + j);
        drive_src('0);
        drain(200);
        chk("fair_count", acc_src.size(), 24);
        if (acc_src.size() == 24) begin
            for (int j = 0; j < 24; j++) begin
                ed = (j < 8) ? 32'h1000 + j : (j < 16) ? 32'h2000 + (j - 8) : 32'h1000 + (j - 8);
                chk("fair_src", acc_src[j], (j >= 8 && j < 16) ? 0 : 1);
                chk("fair_data", acc_data[j], ed);
                if (j > 0) chk("fair_gap", acc_cyc[j] - acc_cyc[j-1], (j % 8 == 0) ? 2 : 1);
            end
        end

        // Backpressure mid-burst; src1 beats carry ID 0x05.
        clear_logs();
        for (int j = 0; j < 4; j++) pend[0].push_back(32'h3000 + j);
        pend[1].push_back(32'h05B1); pend[1].push_back(32'h05B2);
        drive_src('0);
        step(); step(); step();
        atready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("bp_hold_valid", last_atvalid, 1'b1);
            chk("bp_hold_data", last_atdata, 32'h3002);
            chk("bp_no_ready", last_rdy, '0);
        end
        atready = 1'b1;
        drain(100);
        chk("bp_count", acc_src.size(), 6);
        if (acc_src.size() == 6) begin
            chk("bp_data2", acc_data[2], 32'h3002);
            chk("bp_stall_gap", acc_cyc[2] - acc_cyc[1], 6);
            chk("bp_src1", acc_src[4], 1);
`ifdef ATB_FUNNEL_ID_OVERRIDE_EN
            chk("bp_id", acc_id[4], 7'h11);
`else
            chk("bp_id", acc_id[4], 7'h05);
`endif
        end

        // Flush with staggered acks while data flows.
        pend[1].push_back(32'h4001); pend[1].push_back(32'h4002);
        first_t = -1; pulse_cnt = 0; last_pulse = -1;
        afvalid = 1'b1;
        step(); step();
        chk("flush_req_seen", first_t >= 0, 1'b1);
        step();
        src_afready = 2'b10; step();
        src_afready = 2'b00; step();
        src_afready = 2'b01; step();
        src_afready = 2'b00;
        repeat (4) step();
        afvalid = 1'b0;
        step(); step();
        chk("flush_pulses", pulse_cnt, 1);
        chk("flush_pulse_cycle", last_pulse, first_t + 4);
        drain(100);

        // Async reset during a src1 burst; arbitration restarts at src0.
        clear_logs();
        for (int j = 0; j < 10; j++) pend[1].push_back(32'h5000 + j);
        drive_src('0);
        n = 0;
        while (acc_src.size() < 4 && n < 50) begin step(); n++; end
        chk("rst_burst_reached", acc_src.size(), 4);
        for (int j = 0; j < 3; j++) pend[0].push_back(32'h6000 + j);
        drive_src('0);
        chk("pre_rst_atvalid", atvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_atvalid", atvalid, 1'b0);
        chk("async_rst_src_atready", src_atready, '0);
        chk("async_rst_afready", afready, 1'b0);
        step(); step();
        rst = 1'b0;
        clear_logs();
        drain(100);
        chk("post_rst_count", acc_src.size(), 9);
        if (acc_src.size() > 0) chk("post_rst_first_src", acc_src[0], 0);

        // Random traffic, flushes, gaps and one reset.
        gap_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            atready = ($urandom_range(0, 3) != 0);
            src_afready = N'($urandom);
            if ($urandom_range(0, 15) == 0) afvalid = ~afvalid;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0 && pend[i].size() < 6) pend[i].push_back($urandom);
            rst = (c == 1500);
            step();
        end
        rst = 1'b0;
        atready = 1'b1;
        drain(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
